// File: rtl/vcve2_pkg.sv
// Shared types for the multiply/divide controller: operator encoding, controller FSM states
// and intermediate-register width. DONE exists only when CVE2_MULTDIV_CTRL_RSP_BUF_EN is defined.
package vcve2_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

`ifdef CVE2_MULTDIV_CTRL_RSP_BUF_EN
    typedef enum logic [1:0] {
        MD_CTRL_IDLE = 2'd0,
        MD_CTRL_BUSY = 2'd1,
        MD_CTRL_DONE = 2'd2
    } md_ctrl_fsm_e;
`else
    typedef enum logic [1:0] {
        MD_CTRL_IDLE = 2'd0,
        MD_CTRL_BUSY = 2'd1
    } md_ctrl_fsm_e;
`endif

    localparam int unsigned IMD_W = 34;

    function automatic logic md_is_mult(input md_op_e op);
        return (op == MD_OP_MULL) || (op == MD_OP_MULH);
    endfunction

endpackage

// File: rtl/cve2_multdiv_ctrl_imd.sv
// Two 34-bit intermediate registers for the multiply/divide engine, each with its own
// write enable; writable in every controller state, cleared by reset.
module cve2_multdiv_ctrl_imd
    import vcve2_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IMD_W-1:0] imd_val_d_i [2],
    input  logic [1:0]       imd_val_we_i,
    output logic [IMD_W-1:0] imd_val_q_o [2]
);

    logic [IMD_W-1:0] imd_val_q [2];
    logic [IMD_W-1:0] imd_val_d [2];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            imd_val_d[k] = imd_val_we_i[k] ? imd_val_d_i[k] : imd_val_q[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            imd_val_q[0] <= '0;
            imd_val_q[1] <= '0;
        end else begin
            imd_val_q[0] <= imd_val_d[0];
            imd_val_q[1] <= imd_val_d[1];
        end
    end

    assign imd_val_q_o[0] = imd_val_q[0];
    assign imd_val_q_o[1] = imd_val_q[1];

endmodule

// File: rtl/cve2_multdiv_ctrl.sv
// Request/response controller around an external multiply/divide engine.
// Define CVE2_MULTDIV_CTRL_RSP_BUF_EN to register the result (DONE state); otherwise it passes through.
module cve2_multdiv_ctrl
    import vcve2_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // a producer holds valid and its payload stable until that edge.
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  md_op_e           req_op_i,
    input  logic [1:0]       req_signed_i,
    input  logic [31:0]      req_a_i,
    input  logic [31:0]      req_b_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_data_o,
    output logic             mult_en_o,
    output logic             div_en_o,
    output md_op_e           operator_o,
    output logic [1:0]       signed_mode_o,
    output logic [31:0]      op_a_o,
    output logic [31:0]      op_b_o,
    input  logic [IMD_W-1:0] imd_val_d_i [2],
    input  logic [1:0]       imd_val_we_i,
    output logic [IMD_W-1:0] imd_val_q_o [2],
    output logic             multdiv_ready_id_o,
    input  logic [31:0]      multdiv_result_i,
    input  logic             valid_i,
    output md_ctrl_fsm_e     fsm_state_o
);

    md_ctrl_fsm_e state_q, state_d;
    md_op_e       op_q, op_d;
    logic [1:0]   sgn_q, sgn_d;
    logic [31:0]  a_q, a_d;
    logic [31:0]  b_q, b_d;
`ifdef CVE2_MULTDIV_CTRL_RSP_BUF_EN
    logic [31:0]  rsp_data_q, rsp_data_d;
`endif

    always_comb begin
        state_d            = state_q;
        op_d               = op_q;
        sgn_d              = sgn_q;
        a_d                = a_q;
        b_d                = b_q;
        req_ready_o        = 1'b0;
        mult_en_o          = 1'b0;
        div_en_o           = 1'b0;
        rsp_valid_o        = 1'b0;
        multdiv_ready_id_o = 1'b0;
`ifdef CVE2_MULTDIV_CTRL_RSP_BUF_EN
        rsp_data_d         = rsp_data_q;
        rsp_data_o         = rsp_data_q;
`else
        rsp_data_o         = multdiv_result_i;
        multdiv_ready_id_o = rsp_ready_i;
`endif

        unique case (state_q)
            MD_CTRL_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    op_d    = req_op_i;
                    sgn_d   = req_signed_i;
                    a_d     = req_a_i;
                    b_d     = req_b_i;
                    state_d = MD_CTRL_BUSY;
                end
            end
            MD_CTRL_BUSY: begin
                mult_en_o = md_is_mult(op_q);
                div_en_o  = !md_is_mult(op_q);
`ifdef CVE2_MULTDIV_CTRL_RSP_BUF_EN
                if (valid_i) begin
                    multdiv_ready_id_o = 1'b1;
                    rsp_data_d         = multdiv_result_i;
                    state_d            = MD_CTRL_DONE;
                end
`else
                rsp_valid_o = valid_i;
                if (valid_i && rsp_ready_i) begin
                    state_d = MD_CTRL_IDLE;
                end
`endif
            end
`ifdef CVE2_MULTDIV_CTRL_RSP_BUF_EN
            MD_CTRL_DONE: begin
                rsp_valid_o = 1'b1;
                // Ready follows the consumer so a new request can ride the response handshake.
                req_ready_o = rsp_ready_i;
                if (rsp_ready_i) begin
                    if (req_valid_i) begin
                        op_d    = req_op_i;
                        sgn_d   = req_signed_i;
                        a_d     = req_a_i;
                        b_d     = req_b_i;
                        state_d = MD_CTRL_BUSY;
                    end else begin
                        state_d = MD_CTRL_IDLE;
                    end
                end
            end
`endif
            default: state_d = MD_CTRL_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= MD_CTRL_IDLE;
            op_q       <= MD_OP_MULL;
            sgn_q      <= 2'b00;
            a_q        <= '0;
            b_q        <= '0;
`ifdef CVE2_MULTDIV_CTRL_RSP_BUF_EN
            rsp_data_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            sgn_q      <= sgn_d;
            a_q        <= a_d;
            b_q        <= b_d;
`ifdef CVE2_MULTDIV_CTRL_RSP_BUF_EN
            rsp_data_q <= rsp_data_d;
`endif
        end
    end

    assign operator_o    = op_q;
    assign signed_mode_o = sgn_q;
    assign op_a_o        = a_q;
    assign op_b_o        = b_q;
    assign fsm_state_o   = state_q;

    cve2_multdiv_ctrl_imd u_imd (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .imd_val_d_i  (imd_val_d_i),
        .imd_val_we_i (imd_val_we_i),
        .imd_val_q_o  (imd_val_q_o)
    );

endmodule
